// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: FSM states, register map, control bits and ADC config-word layout
package adc_seq_pkg;
  typedef enum logic [1:0] {IDLE, CONV, SHIFT, END} state_e;
  localparam logic [3:0] ADDR_CTRL = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;
  localparam int CTRL_RUN = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int CFG_SD = 5;
  localparam int CFG_OS = 4;
  localparam int CFG_S1 = 3;
  localparam int CFG_S0 = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;
  // Single-ended, unipolar, awake config word for channel ch
  function automatic logic [5:0] cfg_word(input logic [2:0] ch);
    logic [5:0] w;
    w = '0;
    w[CFG_SD] = 1'b1;
    w[CFG_OS] = ch[0];
    w[CFG_S1] = ch[2];
    w[CFG_S0] = ch[1];
    w[CFG_UNI] = 1'b1;
    w[CFG_SLP] = 1'b0;
    return w;
  endfunction
endpackage

// File: rtl/adc_seq_frame.sv
// adc_seq_frame: SCK generator, 12-bit config shift-out / result shift-in for one ADC frame
module adc_seq_frame #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [5:0]  cfg_i,
  input  logic        dout_i,
  output logic        sclk_o,
  output logic        din_o,
  output logic        sample_o,
  output logic        done_o,
  output logic [11:0] data_o
);
  localparam int DW = $clog2(CLK_DIV + 1);
  logic          active_q, sclk_q, tick;
  logic [DW-1:0] div_q;
  logic [3:0]    bit_q;
  logic [11:0]   out_q, in_q;
  // sample_o marks the 12th rising SCK; data_o already includes the bit taken there
  assign tick     = active_q && (div_q == DW'(CLK_DIV - 1));
  assign sample_o = tick && !sclk_q && (bit_q == 4'd11);
  assign done_o   = tick && sclk_q && (bit_q == 4'd11);
  assign data_o   = {in_q[10:0], dout_i};
  assign sclk_o   = sclk_q;
  assign din_o    = out_q[11];
  // SCK phases, MSB-first shift-out on falling SCK and shift-in on rising SCK
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      active_q <= 1'b0;
      sclk_q <= 1'b0;
      div_q <= '0;
      bit_q <= '0;
      out_q <= '0;
      in_q <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      sclk_q <= 1'b0;
      div_q <= '0;
      bit_q <= '0;
      out_q <= {cfg_i, 6'b0};
    end else if (active_q) begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        sclk_q <= ~sclk_q;
        if (!sclk_q) in_q <= {in_q[10:0], dout_i};
        else begin
          out_q <= {out_q[10:0], 1'b0};
          bit_q <= bit_q + 4'd1;
          if (bit_q == 4'd11) active_q <= 1'b0;
        end
      end
    end
endmodule

// File: rtl/adc_seq.sv
// adc_seq: multi-channel LTC2308 sequencer with Avalon-MM registers; ADC_SEQ_IRQ_EN enables the sweep-done irq
module adc_seq
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CLK_DIV = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq,
  output logic        adc_sclk,
  output logic        adc_cs_n,
  output logic        adc_din,
  input  logic        adc_dout
);
  localparam int CW = $clog2(CONV_CYCLES + 1);
`ifdef ADC_SEQ_IRQ_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    frame_q, frame_d;
  logic          cs_q;
  logic [2:0]    ctrl_q, ctrl_d, cfg_ch;
  logic          done_q, done_d, irq_q, irq_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [15:0]   res_q [NUM_CH];
  logic          start, sample, fdone, busy, unused_ok;
  logic [11:0]   data;
  assign unused_ok = &{1'b0, avs_writedata[31:3]};
  assign adc_cs_n = cs_q;
  assign avs_readdata = rdata_q;
  assign irq = irq_q;
  adc_seq_frame #(.CLK_DIV(CLK_DIV)) u_frame (
    .clk(clk),
    .reset_n(reset_n),
    .start_i(start),
    .cfg_i(cfg_word(cfg_ch)),
    .dout_i(adc_dout),
    .sclk_o(adc_sclk),
    .din_o(adc_din),
    .sample_o(sample),
    .done_o(fdone),
    .data_o(data)
  );
  // FSM state, conversion timer, frame index and CS register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      frame_q <= '0;
      cs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      frame_q <= frame_d;
      cs_q <= state_d == CONV;
    end
  // Sweep sequencing: NUM_CH+1 frames, then END or stop early when run drops
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: if (ctrl_q[CTRL_RUN]) begin
        state_d = CONV;
        cnt_d = '0;
        frame_d = '0;
      end
      CONV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CONV_CYCLES - 1)) state_d = SHIFT;
      end
      SHIFT: if (fdone) begin
        state_d = !ctrl_q[CTRL_RUN] ? IDLE : (frame_q == 4'(NUM_CH)) ? END : CONV;
        cnt_d = '0;
        frame_d = frame_q + 4'd1;
      end
      default: begin
        state_d = (ctrl_q[CTRL_AUTO] && ctrl_q[CTRL_RUN]) ? CONV : IDLE;
        cnt_d = '0;
        frame_d = '0;
      end
    endcase
  end
  // Frame launch and config channel; the last frame repeats the top channel
  always_comb begin
    start = (state_q == CONV) && (cnt_q == CW'(CONV_CYCLES - 1));
    cfg_ch = (frame_q >= 4'(NUM_CH)) ? 3'(NUM_CH - 1) : frame_q[2:0];
    busy = state_q != IDLE;
  end
  // Frame k carries channel k-1's result; frame 0 data is dropped
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < NUM_CH; i++) res_q[i] <= '0;
    else for (int i = 0; i < NUM_CH; i++) if (sample && frame_q == 4'(i + 1)) res_q[i] <= {1'b1, 3'(i), data};
  // CTRL/STATUS updates, irq and read mux; a done set beats a same-cycle W1C
  always_comb begin
    ctrl_d = ctrl_q;
    if (state_q == END && !ctrl_q[CTRL_AUTO]) ctrl_d[CTRL_RUN] = 1'b0;
    if (avs_write && avs_address == ADDR_CTRL) ctrl_d = avs_writedata[2:0] & CTRL_MASK;
    done_d = (state_q == END) || (done_q && !(avs_write && avs_address == ADDR_STATUS && avs_writedata[STAT_DONE]));
`ifdef ADC_SEQ_IRQ_EN
    irq_d = done_q && ctrl_q[CTRL_IRQ_EN];
`else
    irq_d = 1'b0;
`endif
    rdata_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (avs_address == 4'(i)) rdata_d = {res_q[i][15], 12'b0, res_q[i][14:12], 4'b0, res_q[i][11:0]};
    if (avs_address == ADDR_CTRL) rdata_d = {29'b0, ctrl_q};
    if (avs_address == ADDR_STATUS) rdata_d = {30'b0, done_q, busy};
    rdata_d = avs_read ? rdata_d : rdata_q;
  end
  // Register file state
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ctrl_q <= '0;
      done_q <= 1'b0;
      irq_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      done_q <= done_d;
      irq_q <= irq_d;
      rdata_q <= rdata_d;
    end
endmodule
